// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer with memory handshake,
// watchdog and optional perf counters (MC_SEQ_PERF_EN).
module mc_seq_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             ab_we,
  output logic             alu_we,
  output logic             mdr_we,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam bit WD_EN = (WAIT_MAX > 0);
  localparam int WW    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WLIM = WW'(WAIT_MAX);

  state_t        state_q, state_d;
  logic [6:0]    op_q, op_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    code_q, code_d;

  logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c;
  logic ab_we_c, alu_we_c, mdr_we_c, reg_we_c;
  logic mem_to_reg_c, pc_we_c, pc_src_c;

  logic id_legal;
  logic is_load, is_store, is_br, is_jmp;
  logic wd_hit, waiting;

  // Classify the ID-stage opcode as a recognised RV32I class or not
  always_comb begin
    id_legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: id_legal = 1'b1;
      default:                           id_legal = 1'b0;
    endcase
  end

  // Later stages only look at the opcode captured in ID
  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);
  assign is_br    = (op_q == OP_BR);
  assign is_jmp   = (op_q == OP_JAL) || (op_q == OP_JALR);

  assign waiting = ((state_q == S_IF)  && !imem_ready) ||
                   ((state_q == S_MEM) && !dmem_ready);
  assign wd_hit  = WD_EN && (wait_q == WLIM);

  // Next-state and strobe decode from the state and live ready inputs
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    code_d       = code_q;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    ir_we_c      = 1'b0;
    ab_we_c      = 1'b0;
    alu_we_c     = 1'b0;
    mdr_we_c     = 1'b0;
    reg_we_c     = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = 1'b0;
    unique case (state_q)
      S_IF: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_ID;
        end else if (wd_hit) begin
          imem_req_c = 1'b1;
          code_d     = 2'b10;
          state_d    = S_FAULT;
        end
      end
      S_ID: begin
        ab_we_c = 1'b1;
        op_d    = opcode;
        if (id_legal) begin
          state_d = S_EX;
        end else begin
          code_d  = 2'b01;
          state_d = S_FAULT;
        end
      end
      S_EX: begin
        alu_we_c = 1'b1;
        if (is_br) begin
          pc_we_c  = 1'b1;
          pc_src_c = branch_taken;
          state_d  = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            state_d = S_IF;
          end else begin
            mdr_we_c = 1'b1;
            state_d  = S_WB;
          end
        end else if (wd_hit) begin
          code_d  = 2'b11;
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        mem_to_reg_c = is_load;
        pc_we_c      = 1'b1;
        pc_src_c     = is_jmp;
        state_d      = S_IF;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Wait counter restarts on every state change
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (WD_EN && waiting) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // State, latched opcode, wait counter and fault code registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= '0;
      wait_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      code_q  <= code_d;
    end
  end

  // Everything reads as zero while reset is held
  assign imem_req   = rst_n & imem_req_c;
  assign dmem_req   = rst_n & dmem_req_c;
  assign dmem_we    = rst_n & dmem_we_c;
  assign ir_we      = rst_n & ir_we_c;
  assign ab_we      = rst_n & ab_we_c;
  assign alu_we     = rst_n & alu_we_c;
  assign mdr_we     = rst_n & mdr_we_c;
  assign reg_we     = rst_n & reg_we_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign pc_we      = rst_n & pc_we_c;
  assign pc_src     = rst_n & pc_src_c;
  assign state      = rst_n ? state_q : 3'd0;
  assign fault      = rst_n & (state_q == S_FAULT);
  assign fault_code = rst_n ? code_q : 2'b00;

`ifdef MC_SEQ_PERF_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  // Counters advance while running; retire count follows pc_we
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (state_q != S_FAULT) begin
      cyc_d = cyc_q + 1'b1;
    end
    if (pc_we_c) begin
      ret_d = ret_q + 1'b1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_cnt   = rst_n ? cyc_q : '0;
  assign instret_cnt = rst_n ? ret_q : '0;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: vector table plus directed watchdog, reset and
// counter sequences for mc_seq_ctrl.
module tb_mc_seq_ctrl;

  localparam int CNT_W = 4;
`ifdef MC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] ILL = 7'b1111111;

  // {imem_req,dmem_req,dmem_we,ir_we,ab_we,alu_we,mdr_we,reg_we,m2r,pc_we,pc_src}
  localparam logic [10:0] NO   = 11'b00000000000;
  localparam logic [10:0] IFR  = 11'b10010000000;
  localparam logic [10:0] IFW  = 11'b10000000000;
  localparam logic [10:0] IDS  = 11'b00001000000;
  localparam logic [10:0] EXS  = 11'b00000100000;
  localparam logic [10:0] BRT  = 11'b00000100011;
  localparam logic [10:0] BRN  = 11'b00000100010;
  localparam logic [10:0] WB   = 11'b00000001010;
  localparam logic [10:0] WBL  = 11'b00000001110;
  localparam logic [10:0] WBJ  = 11'b00000001011;
  localparam logic [10:0] MEML = 11'b01000010000;
  localparam logic [10:0] MEMS = 11'b01100000010;
  localparam logic [10:0] MEMW = 11'b01000000000;

  logic clk = 1'b0;
  logic rst_n, branch_taken, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic imem_req, dmem_req, dmem_we, ir_we, ab_we, alu_we;
  logic mdr_we, reg_we, mem_to_reg, pc_we, pc_src, fault;
  logic [2:0] state;
  logic [1:0] fault_code;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_seq_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .ab_we(ab_we), .alu_we(alu_we), .mdr_we(mdr_we),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .pc_we(pc_we),
    .pc_src(pc_src), .state(state), .fault(fault),
    .fault_code(fault_code), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  typedef struct packed {
    logic        r;
    logic [6:0]  op;
    logic        br;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [10:0] sb;
    logic        f;
    logic [1:0]  c;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [6:0] op, logic br,
                              logic ir, logic dr, logic [2:0] st,
                              logic [10:0] sb, logic f, logic [1:0] c);
    vec_t v;
    v.r = r; v.op = op; v.br = br; v.ir = ir; v.dr = dr;
    v.st = st; v.sb = sb; v.f = f; v.c = c;
    return v;
  endfunction

  function automatic logic [10:0] strobes();
    return {imem_req, dmem_req, dmem_we, ir_we, ab_we, alu_we,
            mdr_we, reg_we, mem_to_reg, pc_we, pc_src};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [6:0] op,
                     input logic br, input logic ir, input logic dr);
    rst_n = r; opcode = op; branch_taken = br;
    imem_ready = ir; dmem_ready = dr;
    #1;
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1);
  end

  initial begin
    int ncyc;
    logic ok;
    rst_n = 1'b0; opcode = '0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    adv();

    vq.push_back(mk(0, 7'd0, 0, 1, 1, 3'd0, NO,   0, 2'b00));
    vq.push_back(mk(1, OPR,  0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, OPR,  0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, OPR,  0, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(1, OPR,  0, 1, 1, 3'd4, WB,   0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, BR,   1, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(1, BR,   1, 1, 1, 3'd3, MEML, 0, 2'b00));
    vq.push_back(mk(1, BR,   1, 1, 1, 3'd4, WBL,  0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd3, MEMS, 0, 2'b00));
    vq.push_back(mk(1, BR,   1, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, BR,   1, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, BR,   1, 1, 1, 3'd2, BRT,  0, 2'b00));
    vq.push_back(mk(1, BR,   0, 0, 1, 3'd0, IFW,  0, 2'b00));
    vq.push_back(mk(1, BR,   0, 0, 1, 3'd0, IFW,  0, 2'b00));
    vq.push_back(mk(1, BR,   0, 0, 1, 3'd0, IFW,  0, 2'b00));
    vq.push_back(mk(1, BR,   0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, BR,   0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, BR,   0, 1, 1, 3'd2, BRN,  0, 2'b00));
    vq.push_back(mk(1, JAL,  0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, JAL,  0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, JAL,  0, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(1, OPR,  0, 1, 1, 3'd4, WBJ,  0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 0, 3'd3, MEMW, 0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 0, 3'd3, MEMW, 0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd3, MEML, 0, 2'b00));
    vq.push_back(mk(1, LD,   0, 1, 1, 3'd4, WBL,  0, 2'b00));
    vq.push_back(mk(1, ILL,  0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, ILL,  0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, ILL,  1, 1, 1, 3'd7, NO,   1, 2'b01));
    vq.push_back(mk(1, OPR,  1, 1, 1, 3'd7, NO,   1, 2'b01));
    vq.push_back(mk(0, OPR,  0, 1, 1, 3'd0, NO,   0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(0, ST,   0, 1, 0, 3'd0, NO,   0, 2'b00));
    vq.push_back(mk(1, ST,   0, 1, 1, 3'd0, IFR,  0, 2'b00));
    vq.push_back(mk(1, LUI,  0, 1, 1, 3'd1, IDS,  0, 2'b00));
    vq.push_back(mk(1, LUI,  0, 1, 1, 3'd2, EXS,  0, 2'b00));
    vq.push_back(mk(1, LUI,  0, 1, 1, 3'd4, WB,   0, 2'b00));

    foreach (vq[i]) begin
      drv(vq[i].r, vq[i].op, vq[i].br, vq[i].ir, vq[i].dr);
      chk($sformatf("vec[%0d] st/strb/f/code", i),
          32'({state, strobes(), fault, fault_code}),
          32'({vq[i].st, vq[i].sb, vq[i].f, vq[i].c}));
      adv();
    end

    // counters clear on reset
    do_reset();
    drv(1'b1, OPR, 1'b0, 1'b0, 1'b0);
    chk("rst cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst instret_cnt", 32'(instret_cnt), 32'd0);

    // dmem timeout on a LOAD
    drv(1'b1, LD, 1'b0, 1'b1, 1'b0); adv();
    drv(1'b1, LD, 1'b0, 1'b1, 1'b0); adv();
    drv(1'b1, LD, 1'b0, 1'b1, 1'b0); adv();
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, LD, 1'b0, 1'b1, 1'b0);
      if (state !== 3'd3 || dmem_req !== 1'b1 || fault !== 1'b0) ok = 1'b0;
      adv();
    end
    chk("dmem wait 16 cycles in MEM", 32'(ok), 32'd1);
    drv(1'b1, LD, 1'b0, 1'b1, 1'b1);
    chk("dmem timeout state", 32'(state), 32'd7);
    chk("dmem timeout code", 32'(fault_code), 32'd3);
    chk("dmem timeout req", 32'({dmem_req, imem_req, fault}), 32'b001);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      adv();
      drv(1'b1, LD, 1'b0, 1'(i), 1'(~i));
      if (state !== 3'd7 || strobes() !== NO) ok = 1'b0;
    end
    chk("fault sticky", 32'(ok), 32'd1);
    adv();

    // imem ready exactly at the limit wins over the watchdog
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drv(1'b1, OPR, 1'b0, 1'b0, 1'b0);
      adv();
    end
    drv(1'b1, OPR, 1'b0, 1'b1, 1'b0);
    chk("ready at limit strb", 32'(strobes()), 32'(IFR));
    adv();
    drv(1'b1, OPR, 1'b0, 1'b1, 1'b0);
    chk("ready at limit state", 32'({state, fault}), 32'({3'd1, 1'b0}));
    adv();

    // imem timeout
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, OPR, 1'b0, 1'b0, 1'b0);
      adv();
    end
    drv(1'b1, OPR, 1'b0, 1'b0, 1'b0);
    chk("imem timeout", 32'({state, fault, fault_code, imem_req}),
        32'({3'd7, 1'b1, 2'b10, 1'b0}));
    adv();

    // 17 zero-wait branches exercise counter wrap
    do_reset();
    ncyc = 0;
    for (int i = 0; i < 17; i++) begin
      drv(1'b1, BR, 1'(i), 1'b1, 1'b1); adv(); ncyc++;
      drv(1'b1, BR, 1'(i), 1'b1, 1'b1); adv(); ncyc++;
      drv(1'b1, BR, 1'(i), 1'b1, 1'b1); adv(); ncyc++;
    end
    drv(1'b1, BR, 1'b0, 1'b0, 1'b0);
    chk("perf state", 32'(state), 32'd0);
    chk("perf instret_cnt", 32'(instret_cnt),
        PERF ? 32'(17 % 16) : 32'd0);
    chk("perf cycle_cnt", 32'(cycle_cnt),
        PERF ? 32'(ncyc % 16) : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
